// File: rtl/debug_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the debug command engine.
// Latency: none (types, constants and pure decode functions only).
// Backpressure: not applicable.
package debug_pkg;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_PAUSE   = 4'd1,
        OP_RESUME  = 4'd2,
        OP_RESET   = 4'd3,
        OP_REG_RD  = 4'd4,
        OP_REG_WR  = 4'd5,
        OP_MEM_RD  = 4'd6,
        OP_MEM_WR  = 4'd7,
        OP_STATUS  = 4'd8,
        OP_BP_SET  = 4'd9,
        OP_BP_CLR  = 4'd10
    } op_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MCU     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Register and memory accesses are only meaningful while the MCU is halted.
    function automatic logic op_needs_pause(logic [3:0] op);
        return op inside {OP_REG_RD, OP_REG_WR, OP_MEM_RD, OP_MEM_WR};
    endfunction

    // Opcodes that strobe the MCU and then wait for it to go idle.
    function automatic logic op_is_mcu(logic [3:0] op);
        return (op inside {OP_PAUSE, OP_RESUME, OP_RESET}) || op_needs_pause(op);
    endfunction

    function automatic logic op_is_defined(logic [3:0] op);
        return op <= OP_BP_CLR;
    endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with full/empty flags.
// Latency: a pushed word is visible at pop_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; nothing is dropped.
module debug_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/debug_cmd_engine.sv
// Debug command engine: queues host commands, strobes the MCU, manages breakpoints and returns responses.
// Latency: local op on an empty queue gives rsp_valid 3 cycles after accept; MCU ops add the WAIT time.
// Backpressure: cmd_ready drops when the queue is full; the response is held until rsp_ready.
module debug_cmd_engine
    import debug_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int NUM_BP      = 4,
    parameter int QDEPTH      = 4,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [1:0]        cmd_size,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] d_rd,
    input  logic              mcu_busy,
    input  logic              mcu_error,
    output logic              pause,
    output logic              resume,
    output logic              mcu_reset,
    output logic              reg_rd,
    output logic              reg_wr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] d_in,
    output logic [1:0]        mem_size,
    output logic              bp_hit
);
    localparam int FW = 4 + ADDR_W + DATA_W + 2;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e            state;
    logic [3:0]        cur_op;
    logic              illegal;
    logic [CW-1:0]     wait_cnt;
    logic              err_mcu;
    logic              paused;
    logic [ADDR_W-1:0] bp_addr [NUM_BP];
    logic [NUM_BP-1:0] bp_en;
    logic              bp_sticky;
    logic              bp_pend;
    logic              suppress;
    logic [ADDR_W-1:0] resume_pc;

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0]     head;
    logic [3:0]        hd_op;
    logic [ADDR_W-1:0] hd_addr;
    logic [DATA_W-1:0] hd_data;
    logic [1:0]        hd_size;
    logic              hd_illegal;
    logic              bp_match, bp_detect, bp_defer, bp_fire;
    logic              idx_ok;
    logic [DATA_W-1:0] status_word;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign {hd_op, hd_addr, hd_data, hd_size} = head;

    debug_cmd_fifo #(.W(FW), .DEPTH(QDEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (cmd_valid && cmd_ready),
        .push_dat ({cmd_op, cmd_addr, cmd_data, cmd_size}),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .pop_dat  (head),
        .empty    (fifo_empty)
    );

    // Command legality and status word are decided from current state, combinationally.
    always_comb begin
        hd_illegal  = !op_is_defined(hd_op) || (op_needs_pause(hd_op) && !paused);
        idx_ok      = int'(addr[3:0]) < NUM_BP;
        status_word = DATA_W'(pc);
        status_word[1:0] = {bp_sticky, paused};
    end

    // Breakpoint compare; after a resume the resume PC itself is ignored until pc moves off it.
    // A hit detected on an edge that launches ISSUE is deferred so the pause never overlaps a command strobe.
    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (bp_addr[i] == pc)) bp_match = 1'b1;
        end
        bp_detect = bp_match && !paused && !bp_pend && !(suppress && (pc == resume_pc));
        bp_defer  = (state == ST_IDLE) && !fifo_empty;
        bp_fire   = bp_pend || (bp_detect && !bp_defer);
    end

    // Main sequencer: command FSM, registered strobes/operands/response, paused and breakpoint state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur_op    <= '0;
            illegal   <= 1'b0;
            wait_cnt  <= '0;
            err_mcu   <= 1'b0;
            paused    <= 1'b0;
            bp_en     <= '0;
            for (int i = 0; i < NUM_BP; i++) bp_addr[i] <= '0;
            bp_sticky <= 1'b0;
            bp_pend   <= 1'b0;
            suppress  <= 1'b0;
            resume_pc <= '0;
            pause     <= 1'b0;
            resume    <= 1'b0;
            mcu_reset <= 1'b0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bp_hit    <= 1'b0;
            addr      <= '0;
            d_in      <= '0;
            mem_size  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_NONE;
        end else begin
            pause     <= 1'b0;
            resume    <= 1'b0;
            mcu_reset <= 1'b0;
            reg_rd    <= 1'b0;
            reg_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bp_hit    <= 1'b0;
            if (suppress && (pc != resume_pc)) suppress <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        cur_op   <= hd_op;
                        addr     <= hd_addr;
                        d_in     <= hd_data;
                        mem_size <= hd_size;
                        illegal  <= hd_illegal;
                        if (!hd_illegal) begin
                            case (hd_op)
                                OP_PAUSE:  pause     <= 1'b1;
                                OP_RESUME: resume    <= 1'b1;
                                OP_RESET:  mcu_reset <= 1'b1;
                                OP_REG_RD: reg_rd    <= 1'b1;
                                OP_REG_WR: reg_wr    <= 1'b1;
                                OP_MEM_RD: mem_rd    <= 1'b1;
                                OP_MEM_WR: mem_wr    <= 1'b1;
                                default:   ;
                            endcase
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    err_mcu  <= 1'b0;
                    rsp_data <= '0;
                    rsp_err  <= ERR_NONE;
                    if (illegal) begin
                        rsp_err   <= ERR_ILLEGAL;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (op_is_mcu(cur_op)) begin
                        err_mcu <= mcu_error;
                        case (cur_op)
                            OP_PAUSE:  paused <= 1'b1;
                            OP_RESUME: begin
                                paused    <= 1'b0;
                                suppress  <= 1'b1;
                                resume_pc <= pc;
                            end
                            OP_RESET:  paused <= 1'b0;
                            default:   ;
                        endcase
                        state <= ST_WAIT;
                    end else begin
                        case (cur_op)
                            OP_STATUS: begin
                                rsp_data  <= status_word;
                                bp_sticky <= 1'b0;
                            end
                            OP_BP_SET, OP_BP_CLR: begin
                                if (!idx_ok) begin
                                    rsp_err <= ERR_ILLEGAL;
                                end else begin
                                    for (int i = 0; i < NUM_BP; i++) begin
                                        if (addr[3:0] == 4'(i)) begin
                                            bp_en[i] <= (cur_op == OP_BP_SET);
                                            if (cur_op == OP_BP_SET) bp_addr[i] <= ADDR_W'(d_in);
                                        end
                                    end
                                end
                            end
                            default: ;
                        endcase
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (mcu_error) err_mcu <= 1'b1;
                    if ((wait_cnt != '0) && !mcu_busy) begin
                        rsp_err <= (err_mcu || mcu_error) ? ERR_MCU : ERR_NONE;
                        if ((cur_op == OP_REG_RD) || (cur_op == OP_MEM_RD)) rsp_data <= d_rd;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_err   <= (err_mcu || mcu_error) ? ERR_MCU : ERR_TIMEOUT;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (bp_fire) begin
                pause     <= 1'b1;
                bp_hit    <= 1'b1;
                paused    <= 1'b1;
                bp_sticky <= 1'b1;
                bp_pend   <= 1'b0;
            end else if (bp_detect && bp_defer) begin
                bp_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Directed self-checking bench for debug_cmd_engine (TIMEOUT_CYC shortened to 20).
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded so the run always reaches its summary.
module tb_debug_cmd_engine;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_addr, cmd_data;
    logic [1:0]  cmd_size;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [31:0] pc, d_rd;
    logic        mcu_busy, mcu_error;
    logic        pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr;
    logic [31:0] addr, d_in;
    logic [1:0]  mem_size;
    logic        bp_hit;

    int tests = 0;
    int fails = 0;
    int n_pause = 0, n_resume = 0, n_reg_rd = 0, n_mem_rd = 0, n_bp_hit = 0;

    always #5 clk = ~clk;

    debug_cmd_engine #(
        .DATA_W(32), .ADDR_W(32), .NUM_BP(4), .QDEPTH(4), .TIMEOUT_CYC(20)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pc(pc), .d_rd(d_rd), .mcu_busy(mcu_busy), .mcu_error(mcu_error),
        .pause(pause), .resume(resume), .mcu_reset(mcu_reset),
        .reg_rd(reg_rd), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr(addr), .d_in(d_in), .mem_size(mem_size), .bp_hit(bp_hit)
    );

    // Strobe pulse counters.
    always @(negedge clk) begin
        if (pause)  n_pause++;
        if (resume) n_resume++;
        if (reg_rd) n_reg_rd++;
        if (mem_rd) n_mem_rd++;
        if (bp_hit) n_bp_hit++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz);
        int n = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_size = sz; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_e);
        int n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, exp_d);
        chk({tag, "_err"}, rsp_err, exp_e);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        cmd_size = '0; rsp_ready = 1'b0; pc = '0; d_rd = '0; mcu_busy = 1'b0; mcu_error = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_strobes", {pause, resume, mcu_reset, reg_rd, reg_wr, mem_rd, mem_wr, bp_hit}, 8'h00);
        chk("rst_addr", addr, 32'h0);
        chk("rst_err", rsp_err, 2'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Local op latency: accept edge, IDLE, ISSUE, then RESP.
        cmd_op = OP_NOP; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("lat_cyc1", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_cyc2", rsp_valid, 1'b0);
        @(negedge clk);
        chk("lat_cyc3", rsp_valid, 1'b1);
        get_rsp("nop", 32'h0, 2'd0);

        // Accesses while running, undefined opcode, status masking.
        send(OP_MEM_RD, 32'h10, 32'h0, 2'd2);
        get_rsp("memrd_run", 32'h0, 2'd3);
        chk("memrd_run_nostrobe", n_mem_rd, 0);
        send(4'hF, 32'h0, 32'h0, 2'd0);
        get_rsp("undef", 32'h0, 2'd3);
        pc = 32'h1237;
        send(OP_STATUS, 32'h0, 32'h0, 2'd0);
        get_rsp("status_run", 32'h1234, 2'd0);
        pc = 32'h0;

        // PAUSE then REG_RD with mcu_busy high for three sampled cycles.
        send(OP_PAUSE, 32'h0, 32'h0, 2'd0);
        get_rsp("pause", 32'h0, 2'd0);
        chk("pause_pulse", n_pause, 1);
        mcu_busy = 1'b1; d_rd = 32'hDEADBEEF;
        send(OP_REG_RD, 32'h5, 32'h0, 2'd0);
        n = 0;
        while (!reg_rd && n < 20) begin @(negedge clk); n++; end
        chk("regrd_issue_addr", addr, 32'h5);
        repeat (3) @(negedge clk);
        chk("regrd_addr_held", addr, 32'h5);
        mcu_busy = 1'b0;
        get_rsp("regrd", 32'hDEADBEEF, 2'd0);
        chk("regrd_one_pulse", n_reg_rd, 1);

        // Timeout: 20 WAIT cycles with mcu_busy stuck high.
        mcu_busy = 1'b1;
        send(OP_MEM_WR, 32'h40, 32'h55, 2'd2);
        n = 0;
        while (!mem_wr && n < 20) begin @(negedge clk); n++; end
        chk("memwr_strobe", mem_wr, 1'b1);
        @(negedge clk);
        n = 1;
        chk("memwr_d_in", d_in, 32'h55);
        chk("memwr_size", mem_size, 2'd2);
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, 21);
        get_rsp("timeout", 32'h0, 2'd2);
        mcu_busy = 1'b0;

        // MCU error reported.
        mcu_error = 1'b1;
        send(OP_REG_WR, 32'h3, 32'hA5, 2'd0);
        get_rsp("mcu_err", 32'h0, 2'd1);
        mcu_error = 1'b0;

        send(OP_RESUME, 32'h0, 32'h0, 2'd0);
        get_rsp("resume", 32'h0, 2'd0);
        chk("resume_pulse", n_resume, 1);

        // Breakpoints.
        send(OP_BP_SET, 32'h0, 32'h100, 2'd0);
        get_rsp("bpset0", 32'h0, 2'd0);
        send(OP_BP_SET, 32'h4, 32'h200, 2'd0);
        get_rsp("bpset_oob", 32'h0, 2'd3);
        chk("bp_none_yet", n_bp_hit, 0);
        pc = 32'h100;
        repeat (4) @(negedge clk);
        chk("bp_hit_once", n_bp_hit, 1);
        chk("bp_pause", n_pause, 2);
        send(OP_RESUME, 32'h0, 32'h0, 2'd0);
        get_rsp("bp_resume", 32'h0, 2'd0);
        repeat (6) @(negedge clk);
        chk("bp_no_retrigger", n_bp_hit, 1);
        send(OP_STATUS, 32'h0, 32'h0, 2'd0);
        get_rsp("status_bp", 32'h102, 2'd0);
        send(OP_STATUS, 32'h0, 32'h0, 2'd0);
        get_rsp("status_clr", 32'h100, 2'd0);
        send(OP_BP_CLR, 32'h0, 32'h0, 2'd0);
        get_rsp("bpclr", 32'h0, 2'd0);
        pc = 32'h104;
        repeat (3) @(negedge clk);
        pc = 32'h100;
        repeat (4) @(negedge clk);
        chk("bp_cleared", n_bp_hit, 1);
        pc = 32'h0;

        // Queue fill with rsp_ready low: one in flight plus four queued.
        send(OP_NOP, 32'h0, 32'h0, 2'd0);
        send(OP_MEM_RD, 32'h0, 32'h0, 2'd0);
        send(OP_BP_SET, 32'h1, 32'h300, 2'd0);
        send(4'hE, 32'h0, 32'h0, 2'd0);
        send(OP_BP_CLR, 32'hF, 32'h0, 2'd0);
        chk("q_full_stall", cmd_ready, 1'b0);
        get_rsp("q0", 32'h0, 2'd0);
        get_rsp("q1", 32'h0, 2'd3);
        get_rsp("q2", 32'h0, 2'd0);
        get_rsp("q3", 32'h0, 2'd3);
        get_rsp("q4", 32'h0, 2'd3);
        chk("q_ready_again", cmd_ready, 1'b1);

        // Reset during WAIT.
        send(OP_PAUSE, 32'h0, 32'h0, 2'd0);
        get_rsp("pause2", 32'h0, 2'd0);
        mcu_busy = 1'b1;
        send(OP_REG_RD, 32'h7, 32'h9, 2'd1);
        n = 0;
        while (!reg_rd && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("wait_addr", addr, 32'h7);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_addr", addr, 32'h0);
        chk("arst_d_in", d_in, 32'h0);
        chk("arst_size", mem_size, 2'd0);
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        mcu_busy = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_no_stale", rsp_valid, 1'b0);
        send(OP_REG_RD, 32'h1, 32'h0, 2'd0);
        get_rsp("post_rst_regrd", 32'h0, 2'd3);
        chk("regrd_total", n_reg_rd, 2);
        pc = 32'h48;
        send(OP_STATUS, 32'h0, 32'h0, 2'd0);
        get_rsp("post_rst_status", 32'h48, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
